// File: rtl/ifm_pad_writer_if.sv
// Stream input and buffer write-side bundle for ifm_pad_writer.
// The master modport is the pad writer itself; slave is its environment.
interface ifm_pad_writer_if #(
  parameter int ADDR_BIT = 15
);
  logic                s_valid;
  logic                s_ready;
  logic [31:0]         s_data;
  logic                ifm_consumed;
  logic [ADDR_BIT-2:0] bram_addr_write;
  logic                bram_en_write;
  logic [3:0]          in_0;
  logic [3:0]          in_1;
  logic [3:0]          in_2;
  logic [3:0]          in_3;
  logic [3:0]          in_4;
  logic [3:0]          in_5;
  logic [3:0]          in_6;
  logic [3:0]          in_7;
  logic                buf_sel;
  logic                frame_rdy;

  modport master (
    input  s_valid, s_data, ifm_consumed,
    output s_ready, bram_addr_write, bram_en_write,
    output in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7,
    output buf_sel, frame_rdy
  );

  modport slave (
    output s_valid, s_data, ifm_consumed,
    input  s_ready, bram_addr_write, bram_en_write,
    input  in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7,
    input  buf_sel, frame_rdy
  );
endinterface

// File: rtl/ifm_pad_writer.sv
// Writes a zero-padded raster frame into the write half of the ping-pong
// IFM buffer and swaps halves once the reader has released the other one.
module ifm_pad_writer #(
  parameter int IMG_W    = 112,
  parameter int IMG_H    = 112,
  parameter int PAD      = 1,
  parameter int ADDR_BIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  ifm_pad_writer_if.master bus
);

  localparam int WP = IMG_W + 2 * PAD;
  localparam int HP = IMG_H + 2 * PAD;
  localparam int AW = ADDR_BIT - 1;
  localparam int CW = (WP > 1) ? $clog2(WP) : 1;
  localparam int RW = (HP > 1) ? $clog2(HP) : 1;

  typedef enum logic {
    WRITE,
    WAIT_SWAP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [AW-1:0] addr_cnt;
  logic          interior;
  logic          is_last;
  logic          advance;
  logic          swap;
  logic          bank_free;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic          en_q;
  logic          buf_sel_q;
  logic          frame_rdy_q;

  // Border positions advance on their own; interior ones wait for a beat.
  always_comb begin
    interior   = (row >= RW'(PAD)) && (row < RW'(PAD + IMG_H)) &&
                 (col >= CW'(PAD)) && (col < CW'(PAD + IMG_W));
    is_last    = (row == RW'(HP - 1)) && (col == CW'(WP - 1));
    advance    = 1'b0;
    swap       = 1'b0;
    state_next = state;
    case (state)
      WRITE: begin
        advance = !interior || bus.s_valid;
        if (advance && is_last) state_next = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        swap = bank_free || bus.ifm_consumed;
        if (swap) state_next = WRITE;
      end
    endcase
  end

  assign bus.s_ready = (state == WRITE) && interior;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WRITE;
    else        state <= state_next;
  end

  // Linear address tracks r*WP+c incrementally instead of multiplying.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row      <= '0;
      col      <= '0;
      addr_cnt <= '0;
    end else if (advance) begin
      if (is_last) begin
        row      <= '0;
        col      <= '0;
        addr_cnt <= '0;
      end else begin
        addr_cnt <= addr_cnt + AW'(1);
        if (col == CW'(WP - 1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      en_q <= advance;
      if (advance) begin
        addr_q <= addr_cnt;
        data_q <= interior ? bus.s_data : 32'd0;
      end
    end
  end

  // A consume pulse coinciding with a swap leaves the bank marked free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_free   <= 1'b1;
      buf_sel_q   <= 1'b0;
      frame_rdy_q <= 1'b0;
    end else begin
      bank_free   <= bus.ifm_consumed || (bank_free && !swap);
      buf_sel_q   <= buf_sel_q ^ swap;
      frame_rdy_q <= swap;
    end
  end

  assign bus.bram_en_write   = en_q;
  assign bus.bram_addr_write = addr_q;
  assign bus.buf_sel         = buf_sel_q;
  assign bus.frame_rdy       = frame_rdy_q;
  assign bus.in_0            = data_q[3:0];
  assign bus.in_1            = data_q[7:4];
  assign bus.in_2            = data_q[11:8];
  assign bus.in_3            = data_q[15:12];
  assign bus.in_4            = data_q[19:16];
  assign bus.in_5            = data_q[23:20];
  assign bus.in_6            = data_q[27:24];
  assign bus.in_7            = data_q[31:28];

endmodule
